// File: rtl/dpc_pkg.sv
// Shared types and constants for the DPC frame controller.
package dpc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2
    } in_state_e;

    localparam int ERR_W         = 4;
    localparam int ERR_EARLY_EOL = 0;
    localparam int ERR_LATE_EOL  = 1;
    localparam int ERR_SOF_MID   = 2;
    localparam int ERR_NO_SOF    = 3;

endpackage

// File: rtl/dpc_geom_counter.sv
// Input-side column/row tracker with end-of-line checking and SOF resync.
module dpc_geom_counter
    import dpc_pkg::*;
#(
    parameter int CNT_WIDTH    = 10,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 512
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 sof_i,
    input  logic                 beat_i,
    input  logic                 tuser_i,
    input  logic                 tlast_i,
    output logic [CNT_WIDTH-1:0] col_o,
    output logic [CNT_WIDTH-1:0] row_o,
    output logic                 line_end_o,
    output logic                 frame_end_o,
    output logic                 resync_o,
    output logic                 err_early_o,
    output logic                 err_late_o,
    output logic                 err_sof_o
);

    localparam logic [CNT_WIDTH-1:0] LAST_COL = CNT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(FRAME_HEIGHT - 1);

    logic [CNT_WIDTH-1:0] col_q, col_d;
    logic [CNT_WIDTH-1:0] row_q, row_d;
    logic                 at_last;
    logic                 at_origin;
    logic                 plain;

    assign at_last   = (col_q == LAST_COL);
    assign at_origin = (col_q == '0) && (row_q == '0);
    assign plain     = beat_i & ~tuser_i;

    assign resync_o    = beat_i & tuser_i;
    assign err_sof_o   = resync_o & ~at_origin;
    assign line_end_o  = plain & (tlast_i | at_last);
    assign frame_end_o = line_end_o & (row_q == LAST_ROW);
    assign err_early_o = plain & tlast_i & ~at_last;
    assign err_late_o  = plain & ~tlast_i & at_last;

    // A missing tlast at the last column still closes the line.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (sof_i | resync_o) begin
            col_d = CNT_WIDTH'(1);
            row_d = '0;
        end else if (frame_end_o) begin
            col_d = '0;
            row_d = '0;
        end else if (line_end_o) begin
            col_d = '0;
            row_d = row_q + CNT_WIDTH'(1);
        end else if (beat_i) begin
            col_d = col_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;

endmodule

// File: rtl/dpc_frame_ctrl.sv
// Frame controller beside the DPC corrector: arms frames, shadows enable.
// Define DPC_STATS_EN to count corrected bad pixels per output frame.
module dpc_frame_ctrl
    import dpc_pkg::*;
#(
    parameter int CNT_WIDTH    = 10,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 512,
    parameter int STAT_WIDTH   = 20
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cfg_run,
    input  logic                  cfg_single,
    input  logic                  cfg_corr_en,
    input  logic                  err_clr,
    input  logic                  in_tvalid,
    input  logic                  in_tready,
    input  logic                  in_tuser,
    input  logic                  in_tlast,
    input  logic                  out_tvalid,
    input  logic                  out_tready,
    input  logic                  out_tuser,
    input  logic                  out_tlast,
    input  logic                  bp_corrected,
    output logic                  corr_enable,
    output logic                  frame_busy,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic [3:0]            err_flags,
    output logic [CNT_WIDTH-1:0]  in_col,
    output logic [CNT_WIDTH-1:0]  in_row,
    output logic [STAT_WIDTH-1:0] stat_bp_last
);

    localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(FRAME_HEIGHT - 1);

    in_state_e state_q, state_d;
    logic      run_q;
    logic      run_rise;
    logic      in_beat;
    logic      sof_start;
    logic      no_sof;
    logic      act_beat;

    logic g_frame_end, g_resync;
    logic g_err_early, g_err_late, g_err_sof;
    logic unused_line_end;

    logic                 ce_q, ce_d;
    logic [ERR_W-1:0]     err_q, err_d, err_set;
    logic [CNT_WIDTH-1:0] out_row_q, out_row_d, orow_base;
    logic                 out_act_q, out_act_d;
    logic                 out_beat;
    logic                 out_frame_end;
    logic                 done_q;
    logic [15:0]          fcnt_q;

    assign in_beat   = in_tvalid & in_tready;
    assign run_rise  = cfg_run & ~run_q;
    assign sof_start = (state_q == ST_WAIT_SOF) & in_beat & in_tuser;
    assign no_sof    = (state_q == ST_WAIT_SOF) & in_beat & ~in_tuser;
    assign act_beat  = (state_q == ST_ACTIVE) & in_beat;

    dpc_geom_counter #(
        .CNT_WIDTH    (CNT_WIDTH),
        .FRAME_WIDTH  (FRAME_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT)
    ) u_geom (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .sof_i       (sof_start),
        .beat_i      (act_beat),
        .tuser_i     (in_tuser),
        .tlast_i     (in_tlast),
        .col_o       (in_col),
        .row_o       (in_row),
        .line_end_o  (unused_line_end),
        .frame_end_o (g_frame_end),
        .resync_o    (g_resync),
        .err_early_o (g_err_early),
        .err_late_o  (g_err_late),
        .err_sof_o   (g_err_sof)
    );

    // Dropping cfg_run only takes effect once the current frame ends.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_single ? run_rise : cfg_run) state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (sof_start) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (g_frame_end)
                    state_d = (cfg_single | ~cfg_run) ? ST_IDLE : ST_WAIT_SOF;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ce_d = (sof_start | g_resync) ? cfg_corr_en : ce_q;
        err_set                = '0;
        err_set[ERR_EARLY_EOL] = g_err_early;
        err_set[ERR_LATE_EOL]  = g_err_late;
        err_set[ERR_SOF_MID]   = g_err_sof;
        err_set[ERR_NO_SOF]    = no_sof;
        err_d = (err_clr ? '0 : err_q) | err_set;
    end

    assign out_beat      = out_tvalid & out_tready;
    assign orow_base     = out_tuser ? '0 : out_row_q;
    assign out_frame_end = out_beat & out_tlast & (orow_base == LAST_ROW);

    always_comb begin
        out_row_d = out_row_q;
        out_act_d = out_act_q;
        if (out_frame_end) begin
            out_row_d = '0;
            out_act_d = 1'b0;
        end else if (out_beat) begin
            out_row_d = orow_base + CNT_WIDTH'(out_tlast);
            out_act_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            ce_q      <= 1'b0;
            err_q     <= '0;
            out_row_q <= '0;
            out_act_q <= 1'b0;
            done_q    <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= cfg_run;
            ce_q      <= ce_d;
            err_q     <= err_d;
            out_row_q <= out_row_d;
            out_act_q <= out_act_d;
            done_q    <= out_frame_end;
            if (out_frame_end) fcnt_q <= fcnt_q + 16'd1;
        end
    end

`ifdef DPC_STATS_EN
    logic [STAT_WIDTH-1:0] bp_cnt_q, bp_cnt_d, bp_base;
    logic [STAT_WIDTH-1:0] stat_q, stat_d;

    // The frame's final beat is folded in before the snapshot.
    always_comb begin
        bp_base  = out_tuser ? '0 : bp_cnt_q;
        bp_cnt_d = bp_cnt_q;
        stat_d   = stat_q;
        if (out_beat) begin
            bp_cnt_d = (bp_corrected && (bp_base != '1))
                     ? bp_base + STAT_WIDTH'(1) : bp_base;
            if (out_frame_end) stat_d = bp_cnt_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bp_cnt_q <= '0;
            stat_q   <= '0;
        end else begin
            bp_cnt_q <= bp_cnt_d;
            stat_q   <= stat_d;
        end
    end

    assign stat_bp_last = stat_q;
`else
    logic unused_bp;
    assign unused_bp    = bp_corrected;
    assign stat_bp_last = '0;
`endif

    assign corr_enable = ce_q;
    assign frame_busy  = (state_q == ST_ACTIVE) | out_act_q;
    assign frame_done  = done_q;
    assign frame_cnt   = fcnt_q;
    assign err_flags   = err_q;

endmodule

// File: tb/tb_dpc_frame_ctrl.sv
// Scoreboard bench for dpc_frame_ctrl with an 8x4 frame geometry.
module tb_dpc_frame_ctrl;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int CW   = 10;
    localparam int SW   = 20;
    localparam int SMAX = (1 << SW) - 1;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic cfg_run = 0, cfg_single = 0, cfg_corr_en = 0, err_clr = 0;
    logic in_tvalid = 0, in_tready = 0, in_tuser = 0, in_tlast = 0;
    logic out_tvalid = 0, out_tready = 0, out_tuser = 0, out_tlast = 0;
    logic bp_corrected = 0;
    logic          corr_enable, frame_busy, frame_done;
    logic [15:0]   frame_cnt;
    logic [3:0]    err_flags;
    logic [CW-1:0] in_col, in_row;
    logic [SW-1:0] stat_bp_last;

    always #5 aclk = ~aclk;

    dpc_frame_ctrl #(
        .CNT_WIDTH(CW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .STAT_WIDTH(SW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_run(cfg_run), .cfg_single(cfg_single),
        .cfg_corr_en(cfg_corr_en), .err_clr(err_clr),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .in_tuser(in_tuser), .in_tlast(in_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tuser(out_tuser), .out_tlast(out_tlast),
        .bp_corrected(bp_corrected),
        .corr_enable(corr_enable), .frame_busy(frame_busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt),
        .err_flags(err_flags), .in_col(in_col), .in_row(in_row),
        .stat_bp_last(stat_bp_last)
    );

    typedef struct {
        int col; int row; int ce; int busy; int err;
    } st_t;
    typedef struct { int cnt; int stat; } done_t;

    st_t   q_st[$];
    done_t q_done[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state: mode 0 idle, 1 waiting for SOF, 2 in frame.
    int m_mode = 0, m_col = 0, m_row = 0, m_ce = 0, m_err = 0;
    int m_orow = 0, m_oact = 0, m_bpc = 0, m_fcnt = 0;
    bit m_run_prev = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle(bit b, bit u, bit l, bit bp, bit clr);
        int set = 0;
        st_t s;
        done_t d;
        if (m_mode == 0) begin
            if (cfg_single ? (cfg_run && !m_run_prev) : cfg_run) m_mode = 1;
        end else if (b) begin
            if (u) begin
                if (m_mode == 2 && (m_col != 0 || m_row != 0)) set |= 4;
                m_ce = cfg_corr_en; m_col = 1; m_row = 0; m_mode = 2;
            end else if (m_mode == 1) begin
                set |= 8;
            end else begin
                if (l && m_col != W - 1) set |= 1;
                if (!l && m_col == W - 1) set |= 2;
                if (l || m_col == W - 1) begin
                    m_col = 0;
                    m_row++;
                    if (m_row == H) begin
                        m_row = 0;
                        m_mode = (cfg_single || !cfg_run) ? 0 : 1;
                    end
                end else begin
                    m_col++;
                end
            end
        end
        m_err = (clr ? 0 : m_err) | set;
        if (b) begin
            if (u) begin m_orow = 0; m_bpc = 0; end
            if (bp && m_bpc < SMAX) m_bpc++;
            m_oact = 1;
            if (l) begin
                m_orow++;
                if (m_orow == H) begin
                    m_orow = 0; m_oact = 0;
                    m_fcnt = (m_fcnt + 1) % 65536;
                    d.cnt = m_fcnt;
`ifdef DPC_STATS_EN
                    d.stat = m_bpc;
`else
                    d.stat = 0;
`endif
                    q_done.push_back(d);
                end
            end
        end
        m_run_prev = cfg_run;
        if (b) begin
            s.col = m_col; s.row = m_row; s.ce = m_ce;
            s.busy = (m_mode == 2 || m_oact) ? 1 : 0; s.err = m_err;
            q_st.push_back(s);
        end
    endtask

    // Output stream mirrors the input stream (zero-latency corrector).
    task automatic cyc(bit b, bit u, bit l, bit bp, bit clr);
        @(negedge aclk);
        in_tvalid = b ? 1'b1 : 1'($urandom_range(0, 1));
        in_tready = b ? 1'b1 : (in_tvalid ? 1'b0 : 1'($urandom_range(0, 1)));
        in_tuser = u; in_tlast = l;
        out_tvalid = in_tvalid; out_tready = in_tready;
        out_tuser = u; out_tlast = l;
        bp_corrected = bp; err_clr = clr;
        model_cycle(b, u, l, bp, clr);
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(int n, bit clr);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, clr);
    endtask

    task automatic beat(bit u, bit l, bit clr);
        idle($urandom_range(0, 2), 1'b0);
        cyc(1'b1, u, l, 1'($urandom_range(0, 1)), clr);
    endtask

    task automatic send_line(int n, bit last, bit sof);
        for (int i = 0; i < n; i++)
            beat(sof && i == 0, last && i == n - 1, 1'b0);
    endtask

    task automatic send_frame();
        for (int r = 0; r < H; r++) send_line(W, 1'b1, r == 0);
    endtask

    // Monitor: pops expectations whenever the DUT sees a beat or pulses done.
    initial begin
        bit b;
        st_t s;
        done_t d;
        forever begin
            @(posedge aclk);
            b = in_tvalid && in_tready && aresetn;
            #1;
            if (b) begin
                if (q_st.size() == 0) begin
                    chk("st_queue_empty", 1, 0);
                end else begin
                    s = q_st.pop_front();
                    chk("in_col", int'(in_col), s.col);
                    chk("in_row", int'(in_row), s.row);
                    chk("corr_enable", int'(corr_enable), s.ce);
                    chk("frame_busy", int'(frame_busy), s.busy);
                    chk("err_flags", int'(err_flags), s.err);
                end
            end
            if (aresetn && frame_done) begin
                if (q_done.size() == 0) begin
                    chk("unexpected_frame_done", 1, 0);
                end else begin
                    d = q_done.pop_front();
                    chk("frame_cnt", int'(frame_cnt), d.cnt);
                    chk("stat_bp_last", int'(stat_bp_last), d.stat);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge aclk);
        chk("rst_corr_enable", int'(corr_enable), 0);
        chk("rst_frame_busy", int'(frame_busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_err_flags", int'(err_flags), 0);
        chk("rst_in_col", int'(in_col), 0);
        chk("rst_in_row", int'(in_row), 0);
        chk("rst_stat", int'(stat_bp_last), 0);
        aresetn = 1'b1;

        cfg_run = 1; cfg_corr_en = 1;
        idle(3, 1'b0);
        send_frame();
        send_line(W, 1'b1, 1'b1);
        send_line(W, 1'b1, 1'b0);
        cfg_corr_en = 0;
        send_line(W, 1'b1, 1'b0);
        send_line(W, 1'b1, 1'b0);
        send_frame();
        cfg_corr_en = 1;

        send_line(W, 1'b1, 1'b1);
        send_line(6, 1'b1, 1'b0);
        send_line(W, 1'b0, 1'b0);
        send_line(W, 1'b1, 1'b0);
        idle(1, 1'b1);

        send_line(W, 1'b1, 1'b1);
        send_line(W, 1'b1, 1'b0);
        send_line(3, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b1);
        send_line(W - 1, 1'b1, 1'b0);
        for (int r = 1; r < H; r++) send_line(W, 1'b1, 1'b0);
        idle(1, 1'b1);

        beat(1'b0, 1'b0, 1'b0);
        cfg_single = 1; cfg_run = 0;
        send_frame();
        send_frame();
        idle(2, 1'b0);
        cfg_run = 1;
        idle(2, 1'b0);
        send_frame();
        send_frame();
        cfg_run = 0;
        idle(2, 1'b0);
        cfg_run = 1;
        idle(1, 1'b0);
        send_frame();
        cfg_single = 0;

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) cfg_run = ~cfg_run;
            if ($urandom_range(0, 79) == 0) cfg_single = ~cfg_single;
            if ($urandom_range(0, 19) == 0) cfg_corr_en = ~cfg_corr_en;
            beat($urandom_range(0, 39) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 29) == 0);
        end
        idle(5, 1'b0);

        chk("st_queue_drained", q_st.size(), 0);
        chk("done_queue_drained", q_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
